// File: rtl/hs32_sram_arbiter_if.sv
`timescale 1ns/1ps
// Bus bundle for hs32_sram_arbiter: Wishbone slave port, hs32 core memory port and SRAM port-0 pins.
interface hs32_sram_arbiter_if #(
    parameter int AW = 8
);
    logic          wbs_cyc_i;
    logic          wbs_stb_i;
    logic          wbs_we_i;
    logic [3:0]    wbs_sel_i;
    logic [31:0]   wbs_adr_i;
    logic [31:0]   wbs_dat_i;
    logic          wbs_ack_o;
    logic [31:0]   wbs_dat_o;

    logic          cpu_req;
    logic          cpu_we;
    logic [3:0]    cpu_wmask;
    logic [AW-1:0] cpu_addr;
    logic [31:0]   cpu_wdata;
    logic          cpu_ack;
    logic [31:0]   cpu_rdata;

    logic          sram_csb;
    logic          sram_web;
    logic [3:0]    sram_wmask;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_din;
    logic [31:0]   sram_dout;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o,
        input  cpu_req, cpu_we, cpu_wmask, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        output sram_csb, sram_web, sram_wmask, sram_addr, sram_din,
        input  sram_dout
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o,
        output cpu_req, cpu_we, cpu_wmask, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        input  sram_csb, sram_web, sram_wmask, sram_addr, sram_din,
        output sram_dout
    );
endinterface

// File: rtl/hs32_sram_arbiter.sv
`timescale 1ns/1ps
// Two-master arbiter sharing SRAM port 0 between the hs32 core and the Wishbone slave.
// Every granted access walks IDLE -> ACCESS -> RESP; contending masters are served alternately.
module hs32_sram_arbiter #(
    parameter int          AW        = 8,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    hs32_sram_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_WB  = 1'b1;

    state_t        r_state;
    logic          r_owner;
    logic          r_last_grant;
    logic          r_we;
    logic          r_csb;
    logic          r_web;
    logic [3:0]    r_wmask;
    logic [AW-1:0] r_addr;
    logic [31:0]   r_din;
    logic          r_cpu_ack;
    logic          r_wb_ack;

    logic          w_wb_hit;
    logic          w_wb_req;
    logic          w_any_req;
    logic          w_grant_wb;
    logic          w_grant_we;
    logic [3:0]    w_grant_mask;
    logic [AW-1:0] w_grant_addr;
    logic [31:0]   w_grant_data;
    logic          w_unused_adr_lsb;

    assign w_wb_hit  = (bus.wbs_adr_i[31:AW+2] == BASE_ADDR[31:AW+2]);
    assign w_wb_req  = bus.wbs_cyc_i & bus.wbs_stb_i & w_wb_hit;
    assign w_any_req = bus.cpu_req | w_wb_req;

    // Under contention the master that was not served last wins.
    assign w_grant_wb   = w_wb_req & (~bus.cpu_req | (r_last_grant == OWN_CPU));
    assign w_grant_we   = w_grant_wb ? bus.wbs_we_i            : bus.cpu_we;
    assign w_grant_mask = w_grant_wb ? bus.wbs_sel_i           : bus.cpu_wmask;
    assign w_grant_addr = w_grant_wb ? bus.wbs_adr_i[AW+1:2]   : bus.cpu_addr;
    assign w_grant_data = w_grant_wb ? bus.wbs_dat_i           : bus.cpu_wdata;

    assign w_unused_adr_lsb = ^bus.wbs_adr_i[1:0];

    // Arbitration FSM; all SRAM pins and acks are driven from registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state      <= S_IDLE;
            r_owner      <= OWN_CPU;
            r_last_grant <= OWN_WB;
            r_we         <= 1'b0;
            r_csb        <= 1'b1;
            r_web        <= 1'b1;
            r_wmask      <= 4'b0000;
            r_addr       <= {AW{1'b0}};
            r_din        <= 32'h0000_0000;
            r_cpu_ack    <= 1'b0;
            r_wb_ack     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cpu_ack <= 1'b0;
                    r_wb_ack  <= 1'b0;
                    if (w_any_req) begin
                        r_owner      <= w_grant_wb;
                        r_last_grant <= w_grant_wb;
                        r_we         <= w_grant_we;
                        r_csb        <= 1'b0;
                        r_web        <= ~w_grant_we;
                        r_wmask      <= w_grant_we ? w_grant_mask : 4'b0000;
                        r_addr       <= w_grant_addr;
                        r_din        <= w_grant_data;
                        r_state      <= S_ACCESS;
                    end else begin
                        r_state      <= S_IDLE;
                    end
                end
                S_ACCESS: begin
                    r_csb     <= 1'b1;
                    r_web     <= 1'b1;
                    r_wmask   <= 4'b0000;
                    r_cpu_ack <= (r_owner == OWN_CPU);
                    r_wb_ack  <= (r_owner == OWN_WB);
                    r_state   <= S_RESP;
                end
                S_RESP: begin
                    r_cpu_ack <= 1'b0;
                    r_wb_ack  <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_csb     <= 1'b1;
                    r_web     <= 1'b1;
                    r_wmask   <= 4'b0000;
                    r_cpu_ack <= 1'b0;
                    r_wb_ack  <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.sram_csb   = r_csb;
    assign bus.sram_web   = r_web;
    assign bus.sram_wmask = r_wmask;
    assign bus.sram_addr  = r_addr;
    assign bus.sram_din   = r_din;

    // Macro read data is valid during RESP, so it is passed straight through under the ack.
    assign bus.cpu_ack   = r_cpu_ack;
    assign bus.wbs_ack_o = r_wb_ack;
    assign bus.cpu_rdata = (r_cpu_ack & ~r_we) ? bus.sram_dout : 32'h0000_0000;
    assign bus.wbs_dat_o = (r_wb_ack  & ~r_we) ? bus.sram_dout : 32'h0000_0000;

endmodule

// File: tb/tb_hs32_sram_arbiter.sv
`timescale 1ns/1ps
// Scoreboard bench for hs32_sram_arbiter: a transaction-level model predicts grant order,
// ack cycle and read data; a negedge monitor compares every ack and SRAM access against it.
module tb_hs32_sram_arbiter;
    localparam int AW    = 8;
    localparam int NEVER = 32'h3FFF_FFFF;

    typedef struct {
        bit         we;
        logic [3:0] mask;
        logic [7:0] addr;
        logic [31:0] data;
        int         gap;
        bit         drop;
        int         grant;
    } txn_t;

    typedef struct {
        bit          is_wb;
        int          cyc;
        logic [31:0] rdata;
        bit          we;
        logic [3:0]  wmask;
        logic [7:0]  addr;
        logic [31:0] din;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hs32_sram_arbiter_if #(.AW(AW)) bus ();
    hs32_sram_arbiter #(.AW(AW), .BASE_ADDR(32'h3000_0000)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    txn_t        cpu_list[$];
    txn_t        wb_list[$];
    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] ref_mem  [256];
    logic [31:0] sram_mem [256];
    bit          ref_last_wb = 1'b1;
    bit          mon_en = 1'b0;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SRAM macro port 0: captures on the edge ending ACCESS.
    always @(posedge clk) begin
        if (!bus.sram_csb) begin
            if (!bus.sram_web) begin
                for (int b = 0; b < 4; b++)
                    if (bus.sram_wmask[b]) sram_mem[bus.sram_addr][8*b +: 8] <= bus.sram_din[8*b +: 8];
            end else begin
                bus.sram_dout <= sram_mem[bus.sram_addr];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic txn_t mk(input bit we, input logic [3:0] mask, input logic [7:0] addr,
                                input logic [31:0] data);
        txn_t t;
        t.we = we; t.mask = mask; t.addr = addr; t.data = data;
        t.gap = 0; t.drop = 1'b0; t.grant = 0;
        return t;
    endfunction

    task automatic gen_txn(output txn_t t, input bit allow_drop);
        t.we    = 1'($urandom_range(0, 1));
        t.mask  = 4'($urandom);
        t.addr  = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
        t.data  = $urandom;
        t.gap   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
        t.drop  = allow_drop && ($urandom_range(0, 3) == 0);
        t.grant = 0;
    endtask

    // Transaction-level prediction: grant at the earliest edge the arbiter is free and a
    // request is present; ties go to the master not served last; ack one cycle after grant.
    task automatic model_phase(input int s);
        int   ci, wi, cr, wr, c_eff, w_eff, g, fr;
        bit   pick;
        txn_t t;
        exp_t e;
        ci = 0; wi = 0; fr = s + 1;
        cr = (cpu_list.size() > 0) ? s + cpu_list[0].gap + 1 : NEVER;
        wr = (wb_list.size()  > 0) ? s + wb_list[0].gap  + 1 : NEVER;
        while (ci < cpu_list.size() || wi < wb_list.size()) begin
            c_eff = (ci < cpu_list.size()) ? cr : NEVER;
            w_eff = (wi < wb_list.size())  ? wr : NEVER;
            g = (c_eff < w_eff) ? c_eff : w_eff;
            if (g < fr) g = fr;
            if (c_eff <= g && w_eff <= g) pick = !ref_last_wb;
            else                          pick = (w_eff <= g);
            if (pick) begin
                t = wb_list[wi]; t.grant = g; wb_list[wi] = t; wi++;
                if (wi < wb_list.size()) wr = g + 3 + wb_list[wi].gap;
            end else begin
                t = cpu_list[ci]; t.grant = g; cpu_list[ci] = t; ci++;
                if (ci < cpu_list.size()) cr = g + 3 + cpu_list[ci].gap;
            end
            e.is_wb = pick; e.cyc = g + 1; e.we = t.we; e.addr = t.addr; e.din = t.data;
            e.wmask = t.we ? t.mask : 4'h0;
            if (t.we) begin
                for (int b = 0; b < 4; b++)
                    if (t.mask[b]) ref_mem[t.addr][8*b +: 8] = t.data[8*b +: 8];
                e.rdata = 32'h0;
            end else begin
                e.rdata = ref_mem[t.addr];
            end
            exp_q.push_back(e);
            ref_last_wb = pick;
            fr = g + 3;
        end
    endtask

    task automatic cpu_drive(input int s);
        int   a;
        bit   got;
        txn_t t;
        a = s - 1;
        for (int i = 0; i < cpu_list.size(); i++) begin
            t = cpu_list[i];
            while (cyc < a + 1 + t.gap) begin
                bus.cpu_req = 1'b0;
                @(posedge clk); #1;
            end
            bus.cpu_we = t.we; bus.cpu_wmask = t.mask; bus.cpu_addr = t.addr;
            bus.cpu_wdata = t.data; bus.cpu_req = 1'b1;
            got = 1'b0;
            for (int k = 0; k < 40 && !got; k++) begin
                @(negedge clk);
                if (bus.cpu_ack) begin got = 1'b1; a = cyc; end
                else if (t.drop && cyc >= t.grant) bus.cpu_req = 1'b0;
            end
            if (!got) begin
                n_vec++; n_err++;
                $display("FAIL cpu_ack_timeout: got no ack in 40 cycles, expected ack for addr %h", t.addr);
                break;
            end
            @(posedge clk); #1;
        end
        bus.cpu_req = 1'b0;
    endtask

    task automatic wb_drive(input int s);
        int   a;
        bit   got;
        txn_t t;
        a = s - 1;
        for (int i = 0; i < wb_list.size(); i++) begin
            t = wb_list[i];
            while (cyc < a + 1 + t.gap) begin
                bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
                @(posedge clk); #1;
            end
            bus.wbs_we_i = t.we; bus.wbs_sel_i = t.mask; bus.wbs_dat_i = t.data;
            bus.wbs_adr_i = 32'h3000_0000 | {22'd0, t.addr, 2'b00};
            bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1;
            got = 1'b0;
            for (int k = 0; k < 40 && !got; k++) begin
                @(negedge clk);
                if (bus.wbs_ack_o) begin got = 1'b1; a = cyc; end
            end
            if (!got) begin
                n_vec++; n_err++;
                $display("FAIL wb_ack_timeout: got no ack in 40 cycles, expected ack for addr %h", t.addr);
                break;
            end
            @(posedge clk); #1;
        end
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    endtask

    task automatic run_phase();
        int s;
        @(posedge clk); #1;
        s = cyc;
        model_phase(s);
        fork
            cpu_drive(s);
            wb_drive(s);
        join
        repeat (3) @(posedge clk);
        #1;
        chk("pending_acks", 32'(exp_q.size()), 32'h0);
        exp_q.delete();
        cpu_list.delete();
        wb_list.delete();
    endtask

    // Monitor: pops the scoreboard on every ack and checks the SRAM pins every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("ack_exclusive", 32'(bus.cpu_ack & bus.wbs_ack_o), 32'h0);
            if (bus.cpu_ack | bus.wbs_ack_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", 32'(1), 32'h0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("ack_owner", 32'(bus.wbs_ack_o), 32'(mon_e.is_wb));
                    chk("ack_cycle", 32'(cyc), 32'(mon_e.cyc));
                    chk("rdata", bus.wbs_ack_o ? bus.wbs_dat_o : bus.cpu_rdata, mon_e.rdata);
                end
            end else begin
                chk("rdata_gated", bus.cpu_rdata | bus.wbs_dat_o, 32'h0);
            end
            if (exp_q.size() != 0 && cyc == exp_q[0].cyc - 1) begin
                chk("access_csb",   32'(bus.sram_csb),   32'h0);
                chk("access_web",   32'(bus.sram_web),   32'(!exp_q[0].we));
                chk("access_addr",  32'(bus.sram_addr),  32'(exp_q[0].addr));
                chk("access_wmask", 32'(bus.sram_wmask), 32'(exp_q[0].wmask));
                if (exp_q[0].we) chk("access_din", bus.sram_din, exp_q[0].din);
            end else begin
                chk("idle_csb", 32'(bus.sram_csb), 32'h1);
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_csb"},   32'(bus.sram_csb),   32'h1);
        chk({tag, "_web"},   32'(bus.sram_web),   32'h1);
        chk({tag, "_wmask"}, 32'(bus.sram_wmask), 32'h0);
        chk({tag, "_addr"},  32'(bus.sram_addr),  32'h0);
        chk({tag, "_din"},   bus.sram_din,        32'h0);
        chk({tag, "_acks"},  32'({bus.cpu_ack, bus.wbs_ack_o}), 32'h0);
    endtask

    initial begin
        int   nc, nw;
        txn_t t;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i]  = 32'hC3C3_0000 ^ (32'(i) * 32'h0101_0101);
            sram_mem[i] = 32'hC3C3_0000 ^ (32'(i) * 32'h0101_0101);
        end
        bus.sram_dout = 32'h0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_wmask = 4'h0;
        bus.cpu_addr = 8'h00; bus.cpu_wdata = 32'h0;
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
        bus.wbs_sel_i = 4'h0; bus.wbs_adr_i = 32'h0; bus.wbs_dat_i = 32'h0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_outputs("por");
        rst = 1'b0;
        mon_en = 1'b1;

        // Both masters pending straight out of reset: CPU, WB, CPU, WB.
        cpu_list.push_back(mk(1'b1, 4'hF, 8'h0A, 32'h0A0A_1111));
        cpu_list.push_back(mk(1'b0, 4'h0, 8'h14, 32'h0));
        wb_list.push_back(mk(1'b1, 4'hF, 8'h14, 32'h1414_2222));
        wb_list.push_back(mk(1'b0, 4'h0, 8'h0A, 32'h0));
        run_phase();

        wb_list.push_back(mk(1'b1, 4'hF, 8'h04, 32'hDEAD_BEEF));
        wb_list.push_back(mk(1'b0, 4'h0, 8'h04, 32'h0));
        run_phase();

        cpu_list.push_back(mk(1'b1, 4'b0010, 8'h04, 32'h1122_3344));
        cpu_list.push_back(mk(1'b0, 4'h0, 8'h04, 32'h0));
        run_phase();

        wb_list.push_back(mk(1'b1, 4'hF, 8'hFF, 32'hA5A5_A5A5));
        run_phase();
        cpu_list.push_back(mk(1'b0, 4'h0, 8'hFF, 32'h0));
        run_phase();

        // Out-of-window Wishbone cycle must be ignored entirely.
        @(posedge clk); #1;
        bus.wbs_adr_i = 32'h3000_0400; bus.wbs_we_i = 1'b1; bus.wbs_sel_i = 4'hF;
        bus.wbs_dat_i = 32'hBAD0_BAD0; bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("miss_csb", 32'(bus.sram_csb), 32'h1);
            chk("miss_ack", 32'(bus.wbs_ack_o), 32'h0);
        end
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;

        // Reset in the middle of a CPU write: the write and its ack are dropped.
        mon_en = 1'b0;
        @(posedge clk); #1;
        bus.cpu_addr = 8'h04; bus.cpu_wdata = 32'hFFFF_FFFF; bus.cpu_wmask = 4'hF;
        bus.cpu_we = 1'b1; bus.cpu_req = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_pre_csb", 32'(bus.sram_csb), 32'h0);
        rst = 1'b1;
        #1;
        chk_reset_outputs("rst_async");
        bus.cpu_req = 1'b0;
        @(posedge clk); #1;
        chk_reset_outputs("rst_held");
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("rst_no_ack", 32'({bus.cpu_ack, bus.wbs_ack_o}), 32'h0);
            chk("rst_idle_csb", 32'(bus.sram_csb), 32'h1);
        end
        ref_last_wb = 1'b1;
        mon_en = 1'b1;

        cpu_list.push_back(mk(1'b0, 4'h0, 8'h04, 32'h0));
        wb_list.push_back(mk(1'b0, 4'h0, 8'h04, 32'h0));
        run_phase();

        for (int p = 0; p < 14; p++) begin
            nc = int'($urandom_range(0, 5));
            nw = int'($urandom_range(0, 5));
            for (int i = 0; i < nc; i++) begin gen_txn(t, 1'b1); cpu_list.push_back(t); end
            for (int i = 0; i < nw; i++) begin gen_txn(t, 1'b0); wb_list.push_back(t); end
            run_phase();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule
